// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/fetch stage feeding the decoder (optional trace: FETCH_TRACE_EN)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128,
    parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_last,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        target_bad;
    logic        end_seen;

    assign target_bad = (redirect_target[1:0] != 2'b00) || (redirect_target > LAST_PC);
    assign end_seen   = (imem_instr == END_MARKER) || imem_last;

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == S_HALT);
    assign fault       = (state_q == S_FAULT);

    // State register; reset restarts through START so the first imem read can settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath selection: fault, redirect, stall, end-of-program, fetch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        case (state_q)
            S_START: begin
                valid_d = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (redirect_valid && target_bad) begin
                    state_d = S_FAULT;
                    valid_d = 1'b0;
                end else if (redirect_valid) begin
                    // Redirect beats stall and end-of-program; the wrong-path word is squashed
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (stall) begin
                    valid_d = valid_q;
                end else if (end_seen) begin
                    state_d = S_HALT;
                    valid_d = 1'b0;
                end else begin
                    instr_d = imem_instr;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            S_HALT, S_FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_START;
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers: pc and the instruction register presented to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            ipc_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_TRACE_EN
    logic [31:0] fetch_count;
    logic        fetch_load;

    assign fetch_load = (state_q == S_RUN) && !redirect_valid && !stall && !end_seen;

    // Trace counter and log of each valid fetch and of the terminal transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
        end else begin
            if (fetch_load) begin
                fetch_count <= fetch_count + 32'd1;
                $display("fetch pc=%h instr=%h", pc_q, imem_instr);
            end
            if ((state_q == S_RUN) && ((state_d == S_HALT) || (state_d == S_FAULT))) begin
                $display("fetch end count=%0d pc=%h", fetch_count, pc_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_last;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:31];
    int          checks;
    int          errors;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (128),
        .END_MARKER (32'hFFFF_FFFF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .imem_last       (imem_last),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .halted          (halted),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: out-of-range or misaligned reads return all-ones
    assign imem_instr = (imem_addr <= 32'h7C && imem_addr[1:0] == 2'b00) ? mem[imem_addr[6:2]] : 32'hFFFF_FFFF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        imem_last = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0030_0113;
        mem[2] = 32'hFFFF_FFFF;
        for (int i = 3; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);

        // Reset state
        do_reset();
        check("rst_pc", imem_addr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_halt_fault", {30'd0, halted, fault}, 32'd0);

        // START bubble, two fetches, halt on end marker
        step();
        check("start_valid", {31'd0, instr_valid}, 32'd0);
        check("start_pc", imem_addr, 32'h0);
        step();
        check("f0_valid", {31'd0, instr_valid}, 32'd1);
        check("f0_pc", instr_pc, 32'h0);
        check("f0_instr", instr_out, 32'h0050_0093);
        step();
        check("f1_pc", instr_pc, 32'h4);
        check("f1_instr", instr_out, 32'h0030_0113);
        check("f1_addr", imem_addr, 32'h8);
        step();
        check("end_halted", {31'd0, halted}, 32'd1);
        check("end_valid", {31'd0, instr_valid}, 32'd0);
        check("end_pc", imem_addr, 32'h8);
        step();
        check("halt_hold_pc", imem_addr, 32'h8);
        check("halt_hold", {30'd0, halted, fault}, 32'd2);

        // Redirect at pc=0x8 beats the end marker
        do_reset();
        step(); step(); step();
        redirect_valid = 1'b1; redirect_target = 32'h20;
        step();
        redirect_valid = 1'b0;
        check("redir_pc", imem_addr, 32'h20);
        check("redir_bubble", {31'd0, instr_valid}, 32'd0);
        check("redir_no_halt", {31'd0, halted}, 32'd0);
        step();
        check("redir_ipc", instr_pc, 32'h20);
        check("redir_instr", instr_out, 32'hA000_0008);
        check("redir_valid", {31'd0, instr_valid}, 32'd1);

        // Stall three cycles at pc=0x4
        do_reset();
        step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", imem_addr, 32'h4);
            check("stall_ipc", instr_pc, 32'h0);
            check("stall_instr", instr_out, 32'h0050_0093);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        check("unstall_ipc", instr_pc, 32'h4);
        check("unstall_pc", imem_addr, 32'h8);

        // Stall together with redirect: redirect wins
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h10;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        check("sr_pc", imem_addr, 32'h10);
        check("sr_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("sr_ipc", instr_pc, 32'h10);
        check("sr_instr", instr_out, 32'hA000_0004);

        // Misaligned redirect target faults, pc frozen at 0x14
        redirect_valid = 1'b1; redirect_target = 32'h22;
        step();
        redirect_valid = 1'b0;
        check("mis_fault", {30'd0, halted, fault}, 32'd1);
        check("mis_pc", imem_addr, 32'h14);
        check("mis_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("mis_hold_pc", imem_addr, 32'h14);
        rst_n = 1'b0;
        #1;
        check("mis_rst_fault", {31'd0, fault}, 32'd0);
        check("mis_rst_pc", imem_addr, 32'h0);

        // Out-of-range redirect target 0x80 faults
        do_reset();
        step(); step();
        redirect_valid = 1'b1; redirect_target = 32'h80;
        step();
        redirect_valid = 1'b0;
        check("oor_fault", {31'd0, fault}, 32'd1);
        check("oor_pc", imem_addr, 32'h4);

        // Last legal pc 0x7C: fetch then run off the end into all-ones
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_target = 32'h7C;
        step();
        redirect_valid = 1'b0;
        check("edge_pc", imem_addr, 32'h7C);
        check("edge_fault", {31'd0, fault}, 32'd0);
        step();
        check("edge_instr", instr_out, 32'hA000_001F);
        check("edge_next_pc", imem_addr, 32'h80);
        step();
        check("edge_halt", {30'd0, halted, fault}, 32'd2);
        check("edge_halt_pc", imem_addr, 32'h80);

        // imem_last halts without presenting the word
        do_reset();
        step(); step();
        imem_last = 1'b1;
        step();
        imem_last = 1'b0;
        check("last_halt", {31'd0, halted}, 32'd1);
        check("last_valid", {31'd0, instr_valid}, 32'd0);
        check("last_pc", imem_addr, 32'h4);

        // Asynchronous reset mid-cycle at pc=0x14
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_target = 32'h10;
        step();
        redirect_valid = 1'b0;
        step();
        check("async_pre_pc", imem_addr, 32'h14);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", imem_addr, 32'h0);
        check("async_valid", {31'd0, instr_valid}, 32'd0);
        check("async_instr", instr_out, 32'h0);
        check("async_ipc", instr_pc, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("async_start", {31'd0, instr_valid}, 32'd0);
        step();
        check("async_restart_valid", {31'd0, instr_valid}, 32'd1);
        check("async_restart_ipc", instr_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
